mdu_ctrl: RTL and testbench

MDU_CTRL -- requirements
Module: mdu_ctrl

---
 rtl/mdu_ctrl_pkg.sv | 27 ++
 rtl/mdu_ctrl_if.sv | 14 +
 rtl/mdu_ctrl.sv | 78 +++++++
 tb/tb_mdu_ctrl.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mdu_ctrl_pkg.sv
// mdu_ctrl_pkg: shared pipeline constants for the multiply/divide unit and hazard logic
package mdu_ctrl_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'b000,
        MD_MULT  = 3'b001,
        MD_MULTU = 3'b010,
        MD_DIV   = 3'b011,
        MD_DIVU  = 3'b100,
        MD_MTHI  = 3'b101,
        MD_MTLO  = 3'b110,
        MD_RSVD  = 3'b111
    } md_op_e;

    typedef enum logic {
        S_IDLE,
        S_BUSY
    } mdu_state_e;

    localparam int MULT_CYCLES_DEF = 5;
    localparam int DIV_CYCLES_DEF  = 10;

    function automatic logic is_long_op(input md_op_e op);
        return op inside {MD_MULT, MD_MULTU, MD_DIV, MD_DIVU};
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// mdu_ctrl_if: E-stage request bus and HI/LO result bus of the multiply/divide unit
interface mdu_ctrl_if;
    logic [2:0]  MDOp_E;
    logic [31:0] A;
    logic [31:0] B;
    logic        Req;
    logic        Start;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output MDOp_E, A, B, Req, input Start, Busy, HI, LO);
    modport slave  (input MDOp_E, A, B, Req, output Start, Busy, HI, LO);
endinterface

// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multi-cycle multiply/divide unit with architectural HI/LO registers
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input logic       clk,
    input logic       reset,
    mdu_ctrl_if.slave bus
);
    localparam int MAXC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW   = $clog2(MAXC + 1);

    mdu_state_e  state_q;
    logic [CW-1:0] cnt_q;
    md_op_e      op_q;
    logic [31:0] a_q, b_q, hi_q, lo_q;
    md_op_e      op;
    logic        start;
    logic [63:0] res_d;
    logic        sm, na, nb;
    logic [31:0] ma, mb, qm, rm;

    assign op        = md_op_e'(bus.MDOp_E);
    assign start     = is_long_op(op) && !bus.Req && state_q == S_IDLE;
    assign bus.Start = start;
    assign bus.Busy  = state_q == S_BUSY;
    assign bus.HI    = hi_q;
    assign bus.LO    = lo_q;

    // Result of the latched operation; signed division works on magnitudes, then restores signs
    always_comb begin
        sm    = op_q == MD_MULT;
        na    = op_q == MD_DIV && a_q[31];
        nb    = op_q == MD_DIV && b_q[31];
        ma    = na ? -a_q : a_q;
        mb    = nb ? -b_q : b_q;
        qm    = mb == '0 ? '0 : ma / mb;
        rm    = mb == '0 ? '0 : ma % mb;
        res_d = (op_q == MD_MULT || op_q == MD_MULTU) ?
                    {{32{sm & a_q[31]}}, a_q} * {{32{sm & b_q[31]}}, b_q} :
                b_q == '0 ? {hi_q, lo_q} :
                {na ? -rm : rm, (na ^ nb) ? -qm : qm};
    end

    // Control FSM, latency counter, operand latch and HI/LO update
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            op_q    <= MD_NONE;
            a_q     <= '0;
            b_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
        end else if (state_q == S_IDLE) begin
            if (start) begin
                state_q <= S_BUSY;
                op_q    <= op;
                a_q     <= bus.A;
                b_q     <= bus.B;
                cnt_q   <= (op == MD_MULT || op == MD_MULTU) ? CW'(MULT_CYCLES) : CW'(DIV_CYCLES);
            end else if (!bus.Req && op == MD_MTHI) begin
                hi_q <= bus.A;
            end else if (!bus.Req && op == MD_MTLO) begin
                lo_q <= bus.A;
            end
        end else begin
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
                state_q      <= S_IDLE;
                {hi_q, lo_q} <= res_d;
            end
        end
    end

endmodule

// File: tb/tb_mdu_ctrl.sv
// tb_mdu_ctrl: randomized and directed checks of mdu_ctrl against a behavioural model
module tb_mdu_ctrl;
    localparam int MC = 5;
    localparam int DC = 10;

    logic clk = 0;
    logic reset;
    int   checks = 0;
    int   failures = 0;

    int          m_rem;
    logic [31:0] m_hi, m_lo;
    logic [63:0] m_res;
    logic [63:0] saved;

    mdu_ctrl_if bus();

    mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] ref_result(input logic [2:0] op, input logic [31:0] a,
                                               input logic [31:0] b, input logic [63:0] cur);
        longint sa, sb, q, r;
        logic [63:0] ua, ub;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (op == 3'd1) return 64'(sa * sb);
        if (op == 3'd2) return ua * ub;
        if (b == 0) return cur;
        if (op == 3'd3) begin
            q = sa / sb;
            r = sa % sb;
            return {r[31:0], q[31:0]};
        end
        return {32'(ua % ub), 32'(ua / ub)};
    endfunction

    task automatic step(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic rq, input logic rs);
        logic exp_start;
        bus.MDOp_E = op;
        bus.A      = a;
        bus.B      = b;
        bus.Req    = rq;
        reset      = rs;
        #1;
        exp_start = op >= 3'd1 && op <= 3'd4 && !rq && m_rem == 0;
        if (!rs || op == 3'd0) check("start", 64'(bus.Start), 64'(exp_start && !rs));
        @(posedge clk);
        if (rs) begin
            m_hi  = 0;
            m_lo  = 0;
            m_rem = 0;
        end else if (m_rem > 0) begin
            m_rem--;
            if (m_rem == 0) {m_hi, m_lo} = m_res;
        end else if (exp_start) begin
            m_rem = (op <= 3'd2) ? MC : DC;
            m_res = ref_result(op, a, b, {m_hi, m_lo});
        end else if (!rq && op == 3'd5) begin
            m_hi = a;
        end else if (!rq && op == 3'd6) begin
            m_lo = a;
        end
        @(negedge clk);
        check("busy", 64'(bus.Busy), 64'(m_rem > 0));
        check("hi", 64'(bus.HI), 64'(m_hi));
        check("lo", 64'(bus.LO), 64'(m_lo));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(3'd0, $urandom, $urandom, 1'b0, 1'b0);
    endtask

    initial begin
        m_rem = 0;
        m_hi  = 0;
        m_lo  = 0;
        m_res = 0;
        step(3'd0, 0, 0, 1'b0, 1'b1);
        step(3'd0, 0, 0, 1'b0, 1'b1);
        check("rst_hi", 64'(bus.HI), 64'd0);
        check("rst_busy", 64'(bus.Busy), 64'd0);

        step(3'd1, 32'hFFFF_FFFD, 32'd5, 1'b0, 1'b0);
        check("mult_busy_t1", 64'(bus.Busy), 64'd1);
        idle(MC - 1);
        check("mult_busy_tn", 64'(bus.Busy), 64'd1);
        idle(1);
        check("mult_hi", 64'(bus.HI), 64'hFFFF_FFFF);
        check("mult_lo", 64'(bus.LO), 64'hFFFF_FFF1);

        step(3'd4, 32'd7, 32'd2, 1'b0, 1'b0);
        idle(DC);
        check("divu_lo", 64'(bus.LO), 64'd3);
        check("divu_hi", 64'(bus.HI), 64'd1);
        step(3'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0);
        idle(DC);
        check("div_lo", 64'(bus.LO), 64'hFFFF_FFFD);
        check("div_hi", 64'(bus.HI), 64'hFFFF_FFFF);

        saved = {bus.HI, bus.LO};
        step(3'd2, 32'hFFFF_FFFF, 32'd2, 1'b1, 1'b0);
        check("req_busy", 64'(bus.Busy), 64'd0);
        check("req_hilo", {bus.HI, bus.LO}, saved);

        step(3'd1, 32'd3, 32'd4, 1'b0, 1'b0);
        idle(1);
        step(3'd5, 32'h1234_5678, 32'd0, 1'b0, 1'b0);
        idle(MC - 2);
        check("mthi_ignored", 64'(bus.HI), 64'd0);
        check("mult2_lo", 64'(bus.LO), 64'd12);
        step(3'd6, 32'h0000_ABCD, 32'd0, 1'b0, 1'b0);
        check("mtlo", 64'(bus.LO), 64'hABCD);

        saved = {bus.HI, bus.LO};
        step(3'd3, 32'd100, 32'd0, 1'b0, 1'b0);
        idle(DC - 1);
        check("div0_busy_last", 64'(bus.Busy), 64'd1);
        idle(1);
        check("div0_busy_done", 64'(bus.Busy), 64'd0);
        check("div0_hilo", {bus.HI, bus.LO}, saved);

        step(3'd2, 32'hDEAD_BEEF, 32'h1234, 1'b0, 1'b0);
        idle(2);
        step(3'd0, 0, 0, 1'b0, 1'b1);
        check("rst_mid_busy", 64'(bus.Busy), 64'd0);
        check("rst_mid_hilo", {bus.HI, bus.LO}, 64'd0);
        idle(MC + 2);
        check("rst_no_update", {bus.HI, bus.LO}, 64'd0);

        step(3'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0);
        idle(DC);

        for (int i = 0; i < 600; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            op = 3'($urandom_range(0, 7));
            a  = $urandom;
            b  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = 32'($urandom_range(0, 9)) - 32'd4;
            step(op, a, b, $urandom_range(0, 7) == 0, $urandom_range(0, 60) == 0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
